// File: rtl/core2axi_pkg.sv
// rtl/core2axi_pkg.sv - shared types and constants for the core-side memory arbiter
package core2axi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef logic owner_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/core_arb_owner_fifo.sv
// rtl/core_arb_owner_fifo.sv - in-order owner FIFO recording which requester issued each accepted transaction
module core_arb_owner_fifo
    import core2axi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  owner_t                 push_data_i,
    input  logic                   pop_i,
    output owner_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    owner_t          mem_q [DEPTH];
    owner_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_en;
    logic            pop_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - two-to-one req/gnt/rvalid arbiter in front of core2axi (CORE_ARB_RR_EN selects round-robin)
module core_mem_arbiter
    import core2axi_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  s_req_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic                  s_we_o,
    output logic [3:0]            s_be_o,
    output logic [DATA_WIDTH-1:0] s_wdata_o,
    input  logic                  s_gnt_i,
    input  logic                  s_rvalid_i,
    input  logic [DATA_WIDTH-1:0] s_rdata_i,
    output logic                  err_o
);

    arb_state_t                       state_q, state_d;
    owner_t                           sel_q, sel_d;
    owner_t                           sel;
    logic                             req_active;
    logic [NUM_REQ-1:0]               req_vec;
    logic                             handshake;
    logic                             err_q, err_d;
    owner_t                           fifo_head;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic [$clog2(MAX_OUTSTANDING):0] fifo_count;
    logic                             resp_pop;

`ifdef CORE_ARB_RR_EN
    owner_t prio_q, prio_d;
`endif

    assign req_vec = {m1_req_i, m0_req_i};

    always_comb begin
        sel        = '0;
        req_active = 1'b0;
        if (state_q == HOLD) begin
            sel        = sel_q;
            req_active = req_vec[sel_q];
        end else begin
            req_active = |req_vec;
            case (req_vec)
                2'b01:   sel = 1'b0;
                2'b10:   sel = 1'b1;
`ifdef CORE_ARB_RR_EN
                2'b11:   sel = prio_q;
`else
                2'b11:   sel = 1'b0;
`endif
                default: sel = 1'b0;
            endcase
        end
    end

    // Full is taken from the registered count, so a same-cycle pop never unblocks a request.
    assign s_req_o   = req_active && !fifo_full;
    assign handshake = s_req_o && s_gnt_i;
    assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = sel ? m1_be_i    : m0_be_i;
    assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    assign m0_gnt_o  = handshake && (sel == 1'b0);
    assign m1_gnt_o  = handshake && (sel == 1'b1);

    assign resp_pop    = s_rvalid_i && !fifo_empty;
    assign m0_rvalid_o = resp_pop && (fifo_head == 1'b0);
    assign m1_rvalid_o = resp_pop && (fifo_head == 1'b1);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign err_o       = err_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        err_d   = err_q | (s_rvalid_i && (fifo_count == '0));
        if (!fifo_full) begin
            if (state_q == IDLE) begin
                if (s_req_o && !s_gnt_i) begin
                    state_d = HOLD;
                    sel_d   = sel;
                end
            end else if (!req_active || s_gnt_i) begin
                state_d = IDLE;
            end
        end
    end

`ifdef CORE_ARB_RR_EN
    always_comb begin
        prio_d = prio_q;
        if (handshake) begin
            prio_d = ~sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    core_arb_owner_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (handshake),
        .push_data_i(sel),
        .pop_i      (resp_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed vector bench for core_mem_arbiter (expectations follow CORE_ARB_RR_EN)
module tb_core_mem_arbiter;

`ifdef CORE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m1_req_i;
    logic        m0_gnt_o, m1_gnt_o;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_gnt_i, s_rvalid_i;
    logic [31:0] s_rdata_i;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    core_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .err_o(err_o)
    );

    typedef struct {
        logic        rst_before;
        logic        m0_req, m1_req, gnt, rv;
        logic [31:0] rdata;
        logic        e_sreq, e_g0, e_g1, e_rv0, e_rv1;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic rb, input logic r0, input logic r1, input logic g,
                                input logic rv, input logic [31:0] rd, input logic es,
                                input logic eg0, input logic eg1, input logic erv0,
                                input logic erv1, input logic [31:0] ea);
        vec_t v;
        v.rst_before = rb; v.m0_req = r0; v.m1_req = r1; v.gnt = g; v.rv = rv; v.rdata = rd;
        v.e_sreq = es; v.e_g0 = eg0; v.e_g1 = eg1; v.e_rv0 = erv0; v.e_rv1 = erv1; v.e_addr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic g, input logic rv,
                         input logic [31:0] rd);
        m0_req_i = r0; m1_req_i = r1; s_gnt_i = g; s_rvalid_i = rv; s_rdata_i = rd;
        @(negedge clk_i);
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        #2;
        check("rst_s_req", {31'd0, s_req_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_gnt_rv", {28'd0, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o}, 32'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        m0_addr_i = A0; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = 32'h1111_1111;
        m1_addr_i = A1; m1_we_i = 1'b1; m1_be_i = 4'h3; m1_wdata_i = 32'h2222_2222;

        // Single read by m0, then four simultaneous requests with responses streaming back.
        tbl[0]  = mk(1, 1, 0, 1, 0, 32'h0,         1, 1,   0,  0,   0,  A0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 0,   0,  0,   0,  A0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 0,   0,  0,   0,  A0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 32'hDEADBEEF,  0, 0,   0,  1,   0,  A0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 0,   0,  0,   0,  A0);
        tbl[5]  = mk(1, 1, 1, 1, 0, 32'h0,         1, 1,   0,  0,   0,  A0);
        tbl[6]  = mk(0, 1, 1, 1, 1, 32'hA0000001,  1, !RR, RR, 1,   0,  RR ? A1 : A0);
        tbl[7]  = mk(0, 1, 1, 1, 1, 32'hA0000002,  1, 1,   0,  !RR, RR, A0);
        tbl[8]  = mk(0, 1, 1, 1, 1, 32'hA0000003,  1, !RR, RR, 1,   0,  RR ? A1 : A0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 32'hA0000004,  0, 0,   0,  !RR, RR, A0);
        tbl[10] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0,   0,  0,   0,  A0);

        adv();
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst_before) do_reset();
            drive(tbl[i].m0_req, tbl[i].m1_req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            check($sformatf("v%0d_s_req", i), {31'd0, s_req_o}, {31'd0, tbl[i].e_sreq});
            check($sformatf("v%0d_gnt", i), {30'd0, m0_gnt_o, m1_gnt_o}, {30'd0, tbl[i].e_g0, tbl[i].e_g1});
            check($sformatf("v%0d_rvalid", i), {30'd0, m0_rvalid_o, m1_rvalid_o},
                  {30'd0, tbl[i].e_rv0, tbl[i].e_rv1});
            if (tbl[i].e_sreq) begin
                check($sformatf("v%0d_addr", i), s_addr_o, tbl[i].e_addr);
                check($sformatf("v%0d_we", i), {31'd0, s_we_o}, {31'd0, tbl[i].e_addr == A1});
            end
            if (tbl[i].rv) begin
                check($sformatf("v%0d_rdata0", i), m0_rdata_o, tbl[i].rdata);
                check($sformatf("v%0d_rdata1", i), m1_rdata_o, tbl[i].rdata);
            end
            adv();
        end

        // Grant stall: m0 is held for five cycles despite m1 requesting.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, '0);
            check($sformatf("stall%0d_s_req", i), {31'd0, s_req_o}, 32'd1);
            check($sformatf("stall%0d_addr", i), s_addr_o, A0);
            check($sformatf("stall%0d_gnt", i), {30'd0, m0_gnt_o, m1_gnt_o}, 32'd0);
            adv();
        end
        drive(1, 1, 1, 0, '0);
        check("stall_release_gnt", {30'd0, m0_gnt_o, m1_gnt_o}, 32'd2);
        adv();

        // Latched requester withdraws during HOLD: request drops, then m1 is served.
        do_reset();
        drive(1, 0, 0, 0, '0);
        check("drop_s_req_hold", {31'd0, s_req_o}, 32'd1);
        adv();
        drive(0, 1, 0, 0, '0);
        check("drop_s_req_low", {31'd0, s_req_o}, 32'd0);
        adv();
        drive(0, 1, 1, 0, '0);
        check("drop_m1_gnt", {30'd0, m0_gnt_o, m1_gnt_o}, 32'd1);
        check("drop_m1_addr", s_addr_o, A1);
        adv();

        // Owner FIFO full after two grants; a pop unblocks only on the following cycle.
        do_reset();
        drive(1, 0, 1, 0, '0);
        check("full_g1", {31'd0, m0_gnt_o}, 32'd1);
        adv();
        drive(1, 0, 1, 0, '0);
        check("full_g2", {31'd0, m0_gnt_o}, 32'd1);
        adv();
        drive(1, 0, 1, 1, 32'h5555_AAAA);
        check("full_s_req", {31'd0, s_req_o}, 32'd0);
        check("full_no_gnt", {30'd0, m0_gnt_o, m1_gnt_o}, 32'd0);
        check("full_rv0", {30'd0, m0_rvalid_o, m1_rvalid_o}, 32'd2);
        adv();
        drive(1, 0, 1, 0, '0);
        check("unfull_s_req", {31'd0, s_req_o}, 32'd1);
        check("unfull_gnt", {31'd0, m0_gnt_o}, 32'd1);
        adv();

        // Orphan response sets the sticky error; only reset clears it.
        do_reset();
        drive(0, 0, 0, 1, 32'hBAD0_BAD0);
        check("orphan_no_rv", {30'd0, m0_rvalid_o, m1_rvalid_o}, 32'd0);
        check("orphan_err_before", {31'd0, err_o}, 32'd0);
        adv();
        drive(0, 0, 0, 0, '0);
        check("orphan_err_set", {31'd0, err_o}, 32'd1);
        adv();
        drive(0, 0, 0, 0, '0);
        check("orphan_err_sticky", {31'd0, err_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("orphan_err_cleared", {31'd0, err_o}, 32'd0);
        rst_i = 1'b0;
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
